// File: rtl/packed_trace_logger.sv
// Packs narrow trace samples into buffer words. Trace mode keeps a triggered
// ring-buffer snapshot; stream mode drains the same buffer as a FIFO.
module packed_trace_logger #(
   parameter int TRACE_W = 8,
   parameter int WORD_W  = 32,
   parameter int DEPTH   = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int NW = $clog2($clog2(TRACE_W) + 1),
   localparam int PW = $clog2(WORD_W)
) (
   input  logic               CLK_I,
   input  logic               RST_I,
   input  logic               CONF_UPDATE_I,
   input  logic               MODE_I,
   input  logic [NW-1:0]      NTRACE_I,
   input  logic [AW-1:0]      DELAY_I,
   input  logic [TRACE_W-1:0] TRACE_I,
   input  logic               TRIG_I,
   output logic [WORD_W-1:0]  DATA_O,
   output logic               VALID_O,
   input  logic               READY_I,
   output logic               TRG_EVENT_O,
   output logic [PW-1:0]      EVENT_POS_O,
   output logic [AW-1:0]      EVENT_ADDR_O,
   output logic               DONE_O,
   output logic               OVERFLOW_O,
   output logic [AW:0]        FILL_O
);
   localparam int TLOG = $clog2(TRACE_W);

   typedef enum logic [2:0] {IDLE, ARMED, POST, DONE, STREAM} state_t;
   state_t r_state;
   state_t w_stateNext;

   logic                r_mode;
   logic [NW-1:0]       r_ntrace;
   logic [AW-1:0]       r_delay;
   logic [WORD_W-1:0]   r_pack;
   logic [PW-1:0]       r_bitPos;
   logic                r_commitValid;
   logic [WORD_W-1:0]   r_commitData;
   logic [AW-1:0]       r_wp;
   logic [AW-1:0]       r_rp;
   logic [AW:0]         r_fill;
   logic                r_trgEvent;
   logic [PW-1:0]       r_eventPos;
   logic [AW-1:0]       r_eventAddr;
   logic                r_overflow;
   logic [AW-1:0]       r_postCnt;
   logic [WORD_W-1:0]   r_mem [DEPTH];

   logic [NW-1:0]       w_sLog;
   logic [PW:0]         w_sBits;
   logic [WORD_W-1:0]   w_sampleMask;
   logic [WORD_W-1:0]   w_packNext;
   logic                w_lastSample;
   logic                w_capture;
   logic                w_readout;
   logic                w_valid;
   logic                w_pop;
   logic                w_full;
   logic                w_commitEn;
   logic                w_write;
   logic                w_dropOldest;
   logic                w_overflowSet;
   logic [AW:0]         w_fillNext;
   logic                w_trigHit;
   logic [AW-1:0]       w_curAddr;

   // Sample width S = 2^NTRACE, clamped to the trace port width
   assign w_sLog       = (r_ntrace > NW'(TLOG)) ? NW'(TLOG) : r_ntrace;
   assign w_sBits      = (PW+1)'(1) << w_sLog;
   assign w_sampleMask = (WORD_W'(1) << w_sBits) - WORD_W'(1);
   assign w_packNext   = r_pack | ((WORD_W'(TRACE_I) & w_sampleMask) << r_bitPos);
   assign w_lastSample = (({1'b0, r_bitPos} + w_sBits) == (PW+1)'(WORD_W));

   assign w_capture  = (r_state == ARMED) || (r_state == POST) || (r_state == STREAM);
   assign w_readout  = (r_state == DONE) || (r_state == STREAM);
   assign w_valid    = w_readout && (r_fill != '0);
   assign w_pop      = w_valid && READY_I;
   assign w_full     = (r_fill == (AW+1)'(DEPTH));
   assign w_commitEn = r_commitValid && w_capture;

   // Trace mode always writes and evicts the oldest word when full; stream
   // mode only writes when a slot is free or is being freed this cycle.
   assign w_write       = w_commitEn && (!r_mode || !w_full || w_pop);
   assign w_dropOldest  = w_write && !r_mode && w_full;
   assign w_overflowSet = w_commitEn && r_mode && w_full && !w_pop;
   assign w_fillNext    = r_fill + (AW+1)'(w_write && !w_dropOldest) - (AW+1)'(w_pop);

   assign w_trigHit = TRIG_I && !r_trgEvent && ((r_state == ARMED) || (r_state == STREAM));
   assign w_curAddr = r_wp + AW'(w_write);

   assign DATA_O       = w_valid ? r_mem[r_rp] : '0;
   assign VALID_O      = w_valid;
   assign FILL_O       = r_fill;
   assign DONE_O       = (r_state == DONE);
   assign TRG_EVENT_O  = r_trgEvent;
   assign EVENT_POS_O  = r_eventPos;
   assign EVENT_ADDR_O = r_eventAddr;
   assign OVERFLOW_O   = r_overflow;

   always_ff @(posedge CLK_I) begin
      if (RST_I) r_state <= IDLE;
      else       r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      if (CONF_UPDATE_I) begin
         w_stateNext = MODE_I ? STREAM : ARMED;
      end else begin
         case (r_state)
            ARMED:   if (w_trigHit) w_stateNext = POST;
            POST:    if (w_commitEn && (r_postCnt == AW'(1))) w_stateNext = DONE;
            default: w_stateNext = r_state;
         endcase
      end
   end

   always_ff @(posedge CLK_I) begin
      if (!RST_I && !CONF_UPDATE_I && w_write) r_mem[r_wp] <= r_commitData;
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I || CONF_UPDATE_I) begin
         if (RST_I) begin
            r_mode   <= 1'b0;
            r_ntrace <= '0;
            r_delay  <= '0;
         end else begin
            r_mode   <= MODE_I;
            r_ntrace <= NTRACE_I;
            // Keep at least the trigger word and one older word in the ring
            r_delay  <= (DELAY_I >= AW'(DEPTH - 1)) ? AW'(DEPTH - 2) : DELAY_I;
         end
         r_pack        <= '0;
         r_bitPos      <= '0;
         r_commitValid <= 1'b0;
         r_commitData  <= '0;
         r_wp          <= '0;
         r_rp          <= '0;
         r_fill        <= '0;
         r_trgEvent    <= 1'b0;
         r_eventPos    <= '0;
         r_eventAddr   <= '0;
         r_overflow    <= 1'b0;
         r_postCnt     <= '0;
      end else begin
         if (w_capture) begin
            r_pack        <= w_lastSample ? '0 : w_packNext;
            r_bitPos      <= w_lastSample ? '0 : r_bitPos + w_sBits[PW-1:0];
            r_commitValid <= w_lastSample;
            if (w_lastSample) r_commitData <= w_packNext;
         end else begin
            r_pack        <= '0;
            r_bitPos      <= '0;
            r_commitValid <= 1'b0;
         end
         if (w_write) r_wp <= r_wp + AW'(1);
         r_rp   <= r_rp + AW'(w_pop || w_dropOldest);
         r_fill <= w_fillNext;
         if (w_overflowSet) r_overflow <= 1'b1;
         if (w_trigHit) begin
            r_trgEvent  <= 1'b1;
            r_eventPos  <= r_bitPos;
            r_eventAddr <= w_curAddr;
         end
         // Counts the trigger word plus the post-trigger words still to commit
         if ((r_state == ARMED) && w_trigHit)     r_postCnt <= r_delay + AW'(1);
         else if ((r_state == POST) && w_commitEn) r_postCnt <= r_postCnt - AW'(1);
      end
   end
endmodule

// File: tb/tb_packed_trace_logger.sv
// Self-checking bench for packed_trace_logger: random samples checked against
// a word-level packing model and a queue-based FIFO model.
module tb_packed_trace_logger;
   localparam int TRACE_W = 8;
   localparam int WORD_W  = 32;
   localparam int DEPTH   = 16;
   localparam int AW      = 4;
   localparam int NW      = 2;
   localparam int PW      = 5;

   logic               CLK_I = 1'b0;
   logic               RST_I;
   logic               CONF_UPDATE_I;
   logic               MODE_I;
   logic [NW-1:0]      NTRACE_I;
   logic [AW-1:0]      DELAY_I;
   logic [TRACE_W-1:0] TRACE_I;
   logic               TRIG_I;
   logic [WORD_W-1:0]  DATA_O;
   logic               VALID_O;
   logic               READY_I;
   logic               TRG_EVENT_O;
   logic [PW-1:0]      EVENT_POS_O;
   logic [AW-1:0]      EVENT_ADDR_O;
   logic               DONE_O;
   logic               OVERFLOW_O;
   logic [AW:0]        FILL_O;

   int checks   = 0;
   int failures = 0;

   logic [TRACE_W-1:0] sampleQ[$];
   logic [WORD_W-1:0]  fifoQ[$];
   logic               modelOverflow;
   logic               pendValid;
   logic [WORD_W-1:0]  pendWord;
   logic [WORD_W-1:0]  curWord;
   int                 curK;

   packed_trace_logger dut (
      .CLK_I(CLK_I), .RST_I(RST_I), .CONF_UPDATE_I(CONF_UPDATE_I), .MODE_I(MODE_I),
      .NTRACE_I(NTRACE_I), .DELAY_I(DELAY_I), .TRACE_I(TRACE_I), .TRIG_I(TRIG_I),
      .DATA_O(DATA_O), .VALID_O(VALID_O), .READY_I(READY_I), .TRG_EVENT_O(TRG_EVENT_O),
      .EVENT_POS_O(EVENT_POS_O), .EVENT_ADDR_O(EVENT_ADDR_O), .DONE_O(DONE_O),
      .OVERFLOW_O(OVERFLOW_O), .FILL_O(FILL_O)
   );

   always #5 CLK_I = ~CLK_I;

   task automatic tick();
      @(posedge CLK_I);
      #1;
   endtask

   task automatic doConf(input logic mode, input logic [NW-1:0] nt, input logic [AW-1:0] dly);
      MODE_I = mode; NTRACE_I = nt; DELAY_I = dly;
      TRIG_I = 1'b0; READY_I = 1'b0; CONF_UPDATE_I = 1'b1;
      tick();
      CONF_UPDATE_I = 1'b0;
   endtask

   // Drives one sample per cycle until DONE_O rises or the budget runs out
   task automatic captureTrace(input int sBits, input int trigAt, input bit useCounter,
                               input int budget, output int doneAt);
      logic [TRACE_W-1:0] v;
      doneAt = -1;
      sampleQ.delete();
      for (int j = 0; j < budget && doneAt < 0; j++) begin
         v = useCounter ? TRACE_W'(j) : TRACE_W'($urandom);
         TRACE_I = v;
         TRIG_I  = (j == trigAt);
         sampleQ.push_back(v & TRACE_W'((1 << sBits) - 1));
         tick();
         if (DONE_O === 1'b1) doneAt = j;
      end
      TRIG_I = 1'b0;
   endtask

   function automatic logic [WORD_W-1:0] modelWord(input int w, input int s);
      int spw = WORD_W / s;
      logic [WORD_W-1:0] r = '0;
      for (int k = 0; k < spw; k++) r = r | (WORD_W'(sampleQ[w*spw+k]) << (k*s));
      return r;
   endfunction

   task automatic streamReset();
      fifoQ.delete();
      modelOverflow = 1'b0;
      pendValid = 1'b0;
      pendWord = '0;
      curWord = '0;
      curK = 0;
   endtask

   // Advances the FIFO model across one clock edge
   task automatic streamModelStep(input logic [TRACE_W-1:0] smp, input logic rdy, input int s);
      logic [WORD_W-1:0] tmp;
      if (rdy && fifoQ.size() > 0) tmp = fifoQ.pop_front();
      if (pendValid) begin
         if (fifoQ.size() < DEPTH) fifoQ.push_back(pendWord);
         else modelOverflow = 1'b1;
      end
      curWord = curWord | (WORD_W'(int'(smp) & ((1 << s) - 1)) << (curK * s));
      curK++;
      if (curK == WORD_W / s) begin
         pendValid = 1'b1; pendWord = curWord; curWord = '0; curK = 0;
      end else begin
         pendValid = 1'b0;
      end
   endtask

   task automatic test_reset();
      RST_I = 1'b1; CONF_UPDATE_I = 1'b0; MODE_I = 1'b0; NTRACE_I = '0; DELAY_I = '0;
      TRACE_I = '0; TRIG_I = 1'b0; READY_I = 1'b0;
      tick(); tick();
      checks++;
      if ({DATA_O, VALID_O, FILL_O, DONE_O, TRG_EVENT_O, EVENT_POS_O, EVENT_ADDR_O, OVERFLOW_O} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: data=%h valid=%b fill=%0d done=%b trg=%b got nonzero, expected all 0",
                  DATA_O, VALID_O, FILL_O, DONE_O, TRG_EVENT_O);
      end
      CONF_UPDATE_I = 1'b1; MODE_I = 1'b1; NTRACE_I = 2'd3; READY_I = 1'b0;
      tick();
      RST_I = 1'b0; CONF_UPDATE_I = 1'b0;
      for (int i = 0; i < 12; i++) begin
         TRACE_I = TRACE_W'($urandom);
         tick();
      end
      checks++;
      if (FILL_O !== '0 || VALID_O !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_over_conf: fill=%0d valid=%b, expected fill=0 valid=0", FILL_O, VALID_O);
      end
   endtask

   task automatic test_trace_basic();
      logic [WORD_W-1:0] expWords [5] = '{32'h03020100, 32'h07060504, 32'h0B0A0908,
                                          32'h0F0E0D0C, 32'h13121110};
      int doneAt;
      doConf(1'b0, 2'd3, 4'd2);
      captureTrace(8, 9, 1'b1, 100, doneAt);
      checks++;
      if (doneAt !== 20) begin
         failures++;
         $display("[TB] FAIL basic_done_cycle: got %0d expected 20", doneAt);
      end
      checks++;
      if (TRG_EVENT_O !== 1'b1 || EVENT_POS_O !== 5'd8 || EVENT_ADDR_O !== 4'd2) begin
         failures++;
         $display("[TB] FAIL basic_event: trg=%b pos=%0d addr=%0d expected trg=1 pos=8 addr=2",
                  TRG_EVENT_O, EVENT_POS_O, EVENT_ADDR_O);
      end
      checks++;
      if (FILL_O !== 5'd5) begin
         failures++;
         $display("[TB] FAIL basic_fill: got %0d expected 5", FILL_O);
      end
      READY_I = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (VALID_O !== 1'b1 || DATA_O !== expWords[i]) begin
            failures++;
            $display("[TB] FAIL basic_word%0d: valid=%b data=%h expected valid=1 data=%h",
                     i, VALID_O, DATA_O, expWords[i]);
         end
         tick();
      end
      READY_I = 1'b0;
      checks++;
      if (VALID_O !== 1'b0 || FILL_O !== '0 || DONE_O !== 1'b1) begin
         failures++;
         $display("[TB] FAIL basic_drained: valid=%b fill=%0d done=%b expected 0 0 1", VALID_O, FILL_O, DONE_O);
      end
   endtask

   task automatic test_trace_wrap();
      int doneAt;
      int trigAt = 645;
      int lastWord = trigAt / WORD_W + 14;
      int firstWord = lastWord + 1 - DEPTH;
      logic [WORD_W-1:0] exp;
      // DELAY_I is only AW bits wide, so the largest value exercises the clamp to 14
      doConf(1'b0, 2'd0, 4'd15);
      captureTrace(1, trigAt, 1'b0, 2000, doneAt);
      checks++;
      if (doneAt !== (lastWord + 1) * WORD_W) begin
         failures++;
         $display("[TB] FAIL wrap_done_cycle: got %0d expected %0d", doneAt, (lastWord + 1) * WORD_W);
      end
      checks++;
      if (FILL_O !== 5'd16 || EVENT_POS_O !== PW'(trigAt % WORD_W) || EVENT_ADDR_O !== AW'((trigAt / WORD_W) % DEPTH)) begin
         failures++;
         $display("[TB] FAIL wrap_status: fill=%0d pos=%0d addr=%0d expected 16 %0d %0d",
                  FILL_O, EVENT_POS_O, EVENT_ADDR_O, trigAt % WORD_W, (trigAt / WORD_W) % DEPTH);
      end
      READY_I = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         exp = modelWord(firstWord + i, 1);
         checks++;
         if (VALID_O !== 1'b1 || DATA_O !== exp) begin
            failures++;
            $display("[TB] FAIL wrap_word%0d: valid=%b data=%h expected valid=1 data=%h", i, VALID_O, DATA_O, exp);
         end
         tick();
      end
      READY_I = 1'b0;
   endtask

   task automatic test_stream_backpressure();
      logic [TRACE_W-1:0] smp;
      logic [WORD_W-1:0] expData;
      doConf(1'b1, 2'd3, 4'd0);
      streamReset();
      for (int t = 0; t < 120; t++) begin
         smp = TRACE_W'($urandom);
         TRACE_I = smp;
         READY_I = (t >= 80);
         if (t == 80) begin
            checks++;
            if (FILL_O !== 5'd16 || OVERFLOW_O !== 1'b1) begin
               failures++;
               $display("[TB] FAIL bp_full: fill=%0d ovf=%b expected fill=16 ovf=1", FILL_O, OVERFLOW_O);
            end
         end
         expData = (fifoQ.size() > 0) ? fifoQ[0] : '0;
         checks++;
         if (VALID_O !== (fifoQ.size() > 0) || FILL_O !== (AW+1)'(fifoQ.size()) ||
             OVERFLOW_O !== modelOverflow || (fifoQ.size() > 0 && DATA_O !== expData)) begin
            failures++;
            $display("[TB] FAIL bp_cycle%0d: valid=%b fill=%0d ovf=%b data=%h expected %b %0d %b %h",
                     t, VALID_O, FILL_O, OVERFLOW_O, DATA_O, fifoQ.size() > 0, fifoQ.size(), modelOverflow, expData);
         end
         streamModelStep(smp, READY_I, 8);
         tick();
      end
      READY_I = 1'b0;
   endtask

   task automatic test_stream_full_pop();
      logic [TRACE_W-1:0] smp;
      logic [WORD_W-1:0] expData;
      bit popDone = 1'b0;
      doConf(1'b1, 2'd3, 4'd0);
      streamReset();
      for (int t = 0; t < 72; t++) begin
         smp = TRACE_W'($urandom);
         TRACE_I = smp;
         READY_I = !popDone && (fifoQ.size() == DEPTH) && pendValid;
         if (READY_I) popDone = 1'b1;
         expData = (fifoQ.size() > 0) ? fifoQ[0] : '0;
         checks++;
         if (VALID_O !== (fifoQ.size() > 0) || FILL_O !== (AW+1)'(fifoQ.size()) ||
             OVERFLOW_O !== modelOverflow || (fifoQ.size() > 0 && DATA_O !== expData)) begin
            failures++;
            $display("[TB] FAIL fullpop_cycle%0d: valid=%b fill=%0d ovf=%b data=%h expected %b %0d %b %h",
                     t, VALID_O, FILL_O, OVERFLOW_O, DATA_O, fifoQ.size() > 0, fifoQ.size(), modelOverflow, expData);
         end
         streamModelStep(smp, READY_I, 8);
         tick();
      end
      READY_I = 1'b0;
      checks++;
      if (FILL_O !== 5'd16 || OVERFLOW_O !== 1'b0) begin
         failures++;
         $display("[TB] FAIL fullpop_end: fill=%0d ovf=%b expected fill=16 ovf=0", FILL_O, OVERFLOW_O);
      end
   endtask

   task automatic test_handshake_stall();
      int doneAt;
      int trigAt = $urandom_range(20, 70);
      int lastWord = trigAt / 8 + 3;
      int nWords = lastWord + 1;
      int idx = 0;
      bit stallPrev = 1'b0;
      logic [WORD_W-1:0] prevData = '0;
      logic [WORD_W-1:0] exp;
      doConf(1'b0, 2'd2, 4'd3);
      captureTrace(4, trigAt, 1'b0, 300, doneAt);
      checks++;
      if (doneAt !== nWords * 8 || EVENT_POS_O !== PW'((trigAt % 8) * 4) || EVENT_ADDR_O !== AW'(trigAt / 8)) begin
         failures++;
         $display("[TB] FAIL hs_capture: done=%0d pos=%0d addr=%0d expected %0d %0d %0d",
                  doneAt, EVENT_POS_O, EVENT_ADDR_O, nWords * 8, (trigAt % 8) * 4, trigAt / 8);
      end
      for (int c = 0; c < 300 && idx < nWords; c++) begin
         READY_I = 1'($urandom_range(0, 1));
         checks++;
         if (VALID_O !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hs_valid: got valid=%b expected 1 with %0d words left", VALID_O, nWords - idx);
         end
         if (stallPrev) begin
            checks++;
            if (DATA_O !== prevData) begin
               failures++;
               $display("[TB] FAIL hs_stable: data=%h expected held %h", DATA_O, prevData);
            end
         end
         if (VALID_O === 1'b1 && READY_I) begin
            exp = modelWord(idx, 4);
            checks++;
            if (DATA_O !== exp) begin
               failures++;
               $display("[TB] FAIL hs_word%0d: got %h expected %h", idx, DATA_O, exp);
            end
            idx++;
         end
         stallPrev = (VALID_O === 1'b1) && !READY_I;
         prevData = DATA_O;
         tick();
      end
      READY_I = 1'b0;
      checks++;
      if (idx !== nWords || VALID_O !== 1'b0 || FILL_O !== '0) begin
         failures++;
         $display("[TB] FAIL hs_count: read=%0d valid=%b fill=%0d expected read=%0d valid=0 fill=0",
                  idx, VALID_O, FILL_O, nWords);
      end
   endtask

   task automatic test_reset_mid_readout();
      int doneAt;
      logic [TRACE_W-1:0] smp;
      logic [WORD_W-1:0] expData;
      doConf(1'b0, 2'd3, 4'd2);
      captureTrace(8, 9, 1'b1, 100, doneAt);
      READY_I = 1'b1;
      tick(); tick();
      checks++;
      if (FILL_O !== 5'd3 || DATA_O !== 32'h0B0A0908) begin
         failures++;
         $display("[TB] FAIL rst_pre: fill=%0d data=%h expected fill=3 data=0b0a0908", FILL_O, DATA_O);
      end
      RST_I = 1'b1;
      tick();
      RST_I = 1'b0;
      checks++;
      if ({DATA_O, VALID_O, FILL_O, DONE_O, TRG_EVENT_O, EVENT_POS_O, EVENT_ADDR_O, OVERFLOW_O} !== '0) begin
         failures++;
         $display("[TB] FAIL rst_outputs: data=%h valid=%b fill=%0d done=%b trg=%b pos=%0d addr=%0d, expected all 0",
                  DATA_O, VALID_O, FILL_O, DONE_O, TRG_EVENT_O, EVENT_POS_O, EVENT_ADDR_O);
      end
      for (int i = 0; i < 40; i++) begin
         TRACE_I = TRACE_W'($urandom);
         tick();
      end
      checks++;
      if (FILL_O !== '0 || VALID_O !== 1'b0 || DONE_O !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rst_idle: fill=%0d valid=%b done=%b expected 0 0 0", FILL_O, VALID_O, DONE_O);
      end
      doConf(1'b1, 2'd3, 4'd0);
      streamReset();
      for (int t = 0; t < 30; t++) begin
         smp = TRACE_W'($urandom);
         TRACE_I = smp;
         READY_I = 1'($urandom_range(0, 1));
         expData = (fifoQ.size() > 0) ? fifoQ[0] : '0;
         checks++;
         if (VALID_O !== (fifoQ.size() > 0) || FILL_O !== (AW+1)'(fifoQ.size()) ||
             OVERFLOW_O !== modelOverflow || (fifoQ.size() > 0 && DATA_O !== expData)) begin
            failures++;
            $display("[TB] FAIL restart_cycle%0d: valid=%b fill=%0d ovf=%b data=%h expected %b %0d %b %h",
                     t, VALID_O, FILL_O, OVERFLOW_O, DATA_O, fifoQ.size() > 0, fifoQ.size(), modelOverflow, expData);
         end
         streamModelStep(smp, READY_I, 8);
         tick();
      end
      READY_I = 1'b0;
   endtask

   initial begin
      test_reset();
      test_trace_basic();
      test_trace_wrap();
      test_stream_backpressure();
      test_stream_full_pop();
      test_handshake_stall();
      test_reset_mid_readout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
